// File: rtl/cla_subtractor_seq_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the sequential carry-lookahead subtractor.
//   SLICE_W  - width of the one lookahead slice that is reused every cycle
//   state_t  - controller states (IDLE, RUN, DONE)
//   nslice() - number of slices needed to cover an operand width
// ---------------------------------------------------------------------------
package cla_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/cla_subtractor_seq_slice.sv
// ---------------------------------------------------------------------------
// cla4_slice
// Combinational 4-bit carry-lookahead adder: {cout, s} = x + y + cin.
// The subtractor feeds it x = minuend slice, y = inverted subtrahend slice.
// Ports:
//   x, y  in  4  operand slices
//   cin   in  1  carry in
//   s     out 4  sum
//   cout  out 1  carry out
// ---------------------------------------------------------------------------
module cla4_slice
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  // Propagate/generate terms and flattened lookahead carries.
  always_comb begin
    p    = x | y;
    g    = x & y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    // p = x|y cannot form the sum, so s uses the true XOR of the operands.
    s    = x ^ y ^ c[3:0];
    cout = c[4];
  end

endmodule

// File: rtl/cla_subtractor_seq.sv
// ---------------------------------------------------------------------------
// cla_subtractor_seq
// Multi-cycle subtractor: diff = a - b - bin (mod 2^WIDTH), one 4-bit
// lookahead slice per clock, LSB slice first, via a + ~b + ~bin.
// Optional feature macro: CLA_SUB_OVF_EN adds the signed-overflow port ovf.
// Parameters:
//   WIDTH  operand width, multiple of 4 and >= 4
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      operands present
//   in_ready   out  1      operands accepted (IDLE only)
//   a, b       in   WIDTH  minuend, subtrahend
//   bin        in   1      borrow in
//   out_valid  out  1      result available (DONE)
//   out_ready  in   1      consumer takes result
//   diff       out  WIDTH  a - b - bin
//   bout       out  1      borrow out (a < b + bin, unsigned)
//   ovf        out  1      signed overflow (CLA_SUB_OVF_EN only)
// ---------------------------------------------------------------------------
module cla_subtractor_seq
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef CLA_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_width_check
    $error("cla_subtractor_seq: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t             state_r;
  state_t             state_nx;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   nb_r;      // subtrahend stored already inverted
  logic               carry_r;   // carry = ~borrow between slices
  logic [IDX_W-1:0]   idx_r;
  logic [WIDTH-1:0]   diff_r;
  logic               bout_r;
  logic               in_ready_r;
  logic               out_valid_r;

  logic [SLICE_W-1:0] x_s;
  logic [SLICE_W-1:0] y_s;
  logic [SLICE_W-1:0] s_s;
  logic               c_s;
  logic               last_s;

  assign x_s    = a_r[SLICE_W*idx_r +: SLICE_W];
  assign y_s    = nb_r[SLICE_W*idx_r +: SLICE_W];
  assign last_s = (idx_r == LAST_IDX);

  cla4_slice u_slice (
    .x    (x_s),
    .y    (y_s),
    .cin  (carry_r),
    .s    (s_s),
    .cout (c_s)
  );

  // Next-state logic of the IDLE -> RUN -> DONE controller.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nx = RUN;
        else          state_nx = IDLE;
      end
      RUN: begin
        if (last_s) state_nx = DONE;
        else        state_nx = RUN;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
        else           state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register plus handshake flags registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx;
      in_ready_r  <= (state_nx == IDLE);
      out_valid_r <= (state_nx == DONE);
    end
  end

  // Operand capture, per-slice result writes and final borrow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= {WIDTH{1'b0}};
      nb_r    <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
      diff_r  <= {WIDTH{1'b0}};
      bout_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            nb_r    <= ~b;
            carry_r <= ~bin;
            idx_r   <= {IDX_W{1'b0}};
          end
        end
        RUN: begin
          diff_r[SLICE_W*idx_r +: SLICE_W] <= s_s;
          carry_r <= c_s;
          if (last_s) begin
            idx_r  <= {IDX_W{1'b0}};
            bout_r <= ~c_s;
          end else begin
            idx_r  <= idx_r + IDX_ONE;
          end
        end
        DONE: begin
          // result held until the consumer takes it
        end
        default: begin
          idx_r <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

`ifdef CLA_SUB_OVF_EN
  logic ovf_r;

  // Signed overflow at the final slice: operand signs differ and the
  // result sign differs from the minuend (b[msb] is ~nb_r[msb]).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if ((state_r == RUN) && last_s) begin
      ovf_r <= (a_r[WIDTH-1] ^ ~nb_r[WIDTH-1]) & (a_r[WIDTH-1] ^ s_s[SLICE_W-1]);
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign bout      = bout_r;

endmodule
